// File: rtl/controlador_deslocador_if.sv
// Command/response channel between a requester and controlador_deslocador.
// The master modport is the requester side; the slave modport is the controller side.
interface controlador_deslocador_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SIZE-1:0]  cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_amt;
    logic             cmd_fill;
    logic             cmd_rot;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [SIZE-1:0]  rsp_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_dir,
        output cmd_amt,
        output cmd_fill,
        output cmd_rot,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_dir,
        input  cmd_amt,
        input  cmd_fill,
        input  cmd_rot,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/controlador_deslocador.sv
// Command sequencer driving one deslocador_universal shifter (load/shift/freeze).
// Define DESLOC_ROTATE_EN to honour cmd_rot; otherwise every command is a plain shift.
module controlador_deslocador #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    controlador_deslocador_if.slave bus,
    output logic                    busy,
    output logic [SIZE-1:0]         sh_E,
    output logic                    sh_load,
    output logic                    sh_dir,
    output logic                    sh_Er,
    output logic                    sh_El,
    input  logic [SIZE-1:0]         sh_Y
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  hold_q,  hold_d;
    logic [SIZE-1:0]  data_q,  data_d;
    logic             dir_q,   dir_d;
    logic [CNT_W-1:0] amt_q,   amt_d;
    logic             fill_q,  fill_d;
    logic             rot_q,   rot_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             rot_in;

`ifdef DESLOC_ROTATE_EN
    assign rot_in = bus.cmd_rot;
`else
    logic unused_rot;
    assign unused_rot = bus.cmd_rot;
    assign rot_in     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        dir_d   = dir_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;

        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        busy          = 1'b1;
        // The shifter has no enable, so holding means reloading every cycle.
        sh_load       = 1'b1;
        sh_E          = hold_q;
        sh_dir        = 1'b0;
        sh_Er         = 1'b0;
        sh_El         = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                sh_E          = hold_q;
                if (bus.cmd_valid) begin
                    data_d  = bus.cmd_data;
                    dir_d   = bus.cmd_dir;
                    amt_d   = bus.cmd_amt;
                    fill_d  = bus.cmd_fill;
                    rot_d   = rot_in;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                sh_E = data_q;
                if (amt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = amt_q;
                    state_d = StShift;
                end
            end

            StShift: begin
                sh_load = 1'b0;
                sh_dir  = dir_q;
                if (!dir_q) begin
                    sh_Er = rot_q ? sh_Y[SIZE-1] : fill_q;
                end else begin
                    sh_El = rot_q ? sh_Y[0] : fill_q;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StResp;
                end
            end

            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = sh_Y;
                sh_E          = sh_Y;
                if (bus.rsp_ready) begin
                    hold_d  = sh_Y;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
